// File: rtl/bb_bus_arbiter.sv
// bb_bus_arbiter: bit-serial bus arbiter with one-outstanding split parking and tenure guard.
// Build option: define BB_ARB_RR_EN for round-robin arbitration (default: fixed priority, index 0 highest).
`default_nettype none

module bb_bus_arbiter #(
  parameter int N_MASTERS  = 2,
  parameter int HOLD_LIMIT = 128
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [N_MASTERS-1:0]         breq,
  output logic [N_MASTERS-1:0]         bgrant,
  output logic [$clog2(N_MASTERS)-1:0] gnt_id,
  output logic                         gnt_valid,
  input  logic                         split_in,
  input  logic                         split_release,
  output logic [N_MASTERS-1:0]         split,
  output logic                         hold_err
);

  localparam int MW = $clog2(N_MASTERS);
  localparam int CW = $clog2(HOLD_LIMIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   hold_cnt;
  logic            sp_valid;
  logic            sp_ready;
  logic [MW-1:0]   sp_id;
  logic [N_MASTERS-1:0] eligible;
  logic            pick_valid;
  logic [MW-1:0]   pick_id;
  logic [MW-1:0]   search_start;
  logic [MW:0]     cand;

`ifdef BB_ARB_RR_EN
  logic [MW-1:0]   rr_ptr;
  assign search_start = rr_ptr;

  function automatic logic [MW-1:0] next_ptr(input logic [MW-1:0] id);
    if (id == MW'(N_MASTERS - 1)) return '0;
    return id + 1'b1;
  endfunction
`else
  assign search_start = '0;
`endif

  // The parked split master is invisible to normal arbitration.
  always_comb begin
    eligible = breq;
    if (sp_valid) eligible[sp_id] = 1'b0;
  end

  // Walk from the farthest offset down so the nearest eligible master wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      cand = {1'b0, search_start} + (MW+1)'(k);
      if (cand >= (MW+1)'(N_MASTERS)) cand = cand - (MW+1)'(N_MASTERS);
      if (eligible[cand[MW-1:0]]) begin
        pick_valid = 1'b1;
        pick_id    = cand[MW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      bgrant    <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      split     <= '0;
      hold_err  <= 1'b0;
      hold_cnt  <= '0;
      sp_valid  <= 1'b0;
      sp_ready  <= 1'b0;
      sp_id     <= '0;
`ifdef BB_ARB_RR_EN
      rr_ptr    <= '0;
`endif
    end else begin
      hold_err <= 1'b0;

      if (sp_valid && !breq[sp_id]) begin
        sp_valid     <= 1'b0;
        sp_ready     <= 1'b0;
        split[sp_id] <= 1'b0;
      end else if (sp_valid && split_release) begin
        sp_ready <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (sp_valid && sp_ready && breq[sp_id]) begin
            sp_valid     <= 1'b0;
            sp_ready     <= 1'b0;
            split[sp_id] <= 1'b0;
            bgrant       <= N_MASTERS'(1) << sp_id;
            gnt_id       <= sp_id;
            gnt_valid    <= 1'b1;
            hold_cnt     <= '0;
            state        <= OWN;
`ifdef BB_ARB_RR_EN
            rr_ptr       <= next_ptr(sp_id);
`endif
          end else if (pick_valid) begin
            bgrant    <= N_MASTERS'(1) << pick_id;
            gnt_id    <= pick_id;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            state     <= OWN;
`ifdef BB_ARB_RR_EN
            rr_ptr    <= next_ptr(pick_id);
`endif
          end
        end

        OWN: begin
          if (split_in && !sp_valid) begin
            sp_valid      <= 1'b1;
            sp_ready      <= 1'b0;
            sp_id         <= gnt_id;
            split[gnt_id] <= 1'b1;
            bgrant        <= '0;
            gnt_id        <= '0;
            gnt_valid     <= 1'b0;
            state         <= TURN;
          end else if (!breq[gnt_id]) begin
            bgrant    <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            state     <= TURN;
          end else if (hold_cnt == CNT_LAST) begin
            bgrant    <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            hold_err  <= 1'b1;
            state     <= TURN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        TURN: begin
          hold_cnt <= '0;
          state    <= IDLE;
        end

        default: begin
          bgrant    <= '0;
          gnt_id    <= '0;
          gnt_valid <= 1'b0;
          hold_cnt  <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bb_bus_arbiter.sv
// tb_bb_bus_arbiter: directed vectors, scoreboard queue checked by a negedge monitor.
`default_nettype none

module tb_bb_bus_arbiter;

  localparam int N  = 2;
  localparam int HL = 8;

`ifdef BB_ARB_RR_EN
  localparam logic [1:0] RR_LAST_BG = 2'b10;
`else
  localparam logic [1:0] RR_LAST_BG = 2'b01;
`endif

  logic       clk;
  logic       rstn;
  logic [1:0] breq;
  logic [1:0] bgrant;
  logic [0:0] gnt_id;
  logic       gnt_valid;
  logic       split_in;
  logic       split_release;
  logic [1:0] split;
  logic       hold_err;

  bb_bus_arbiter #(.N_MASTERS(N), .HOLD_LIMIT(HL)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .breq          (breq),
    .bgrant        (bgrant),
    .gnt_id        (gnt_id),
    .gnt_valid     (gnt_valid),
    .split_in      (split_in),
    .split_release (split_release),
    .split         (split),
    .hold_err      (hold_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] bg;
    logic       gid;
    logic       gv;
    logic [1:0] sp;
    logic       he;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  // Drive one cycle of inputs, then queue the outputs expected after the next edge.
  task automatic step(input logic r, input logic [1:0] b, input logic si, input logic sr,
                      input logic [1:0] ebg, input logic [1:0] esp, input logic ehe,
                      input string name);
    exp_t e;
    #1;
    rstn          = r;
    breq          = b;
    split_in      = si;
    split_release = sr;
    @(posedge clk);
    e.bg  = ebg;
    e.gid = ebg[1];
    e.gv  = |ebg;
    e.sp  = esp;
    e.he  = ehe;
    sb_q.push_back(e);
    nm_q.push_back(name);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t  e;
      string n;
      e = sb_q.pop_front();
      n = nm_q.pop_front();
      n_vec++;
      if ({bgrant, gnt_id, gnt_valid, split, hold_err} !== e) begin
        n_err++;
        $display("FAIL %s: got bgrant=%b gnt_id=%b gnt_valid=%b split=%b hold_err=%b, want bgrant=%b gnt_id=%b gnt_valid=%b split=%b hold_err=%b",
                 n, bgrant, gnt_id, gnt_valid, split, hold_err, e.bg, e.gid, e.gv, e.sp, e.he);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; breq = 2'b11; split_in = 1'b0; split_release = 1'b0;
    @(posedge clk);

    // reset with all requests high
    repeat (3) step(0, 2'b11, 0, 0, 2'b00, 2'b00, 0, "reset");

    // contention and handover
    step(1, 2'b11, 0, 0, 2'b01, 2'b00, 0, "contend_m0_first");
    step(1, 2'b11, 0, 0, 2'b01, 2'b00, 0, "m0_holds");
    step(1, 2'b10, 0, 0, 2'b00, 2'b00, 0, "m0_drop_t1");
    step(1, 2'b10, 0, 0, 2'b00, 2'b00, 0, "turnaround_t2");
    step(1, 2'b10, 0, 0, 2'b10, 2'b00, 0, "m1_grant_t3");
    step(1, 2'b01, 0, 0, 2'b00, 2'b00, 0, "m1_drop");
    step(1, 2'b01, 0, 0, 2'b00, 2'b00, 0, "turn_m1");
    step(1, 2'b01, 0, 0, 2'b01, 2'b00, 0, "m0_regrant");

    // split of m0, m1 served meanwhile, then m0 re-granted first
    step(1, 2'b11, 1, 0, 2'b00, 2'b01, 0, "split_accept");
    step(1, 2'b11, 0, 0, 2'b00, 2'b01, 0, "split_turn");
    step(1, 2'b11, 0, 0, 2'b10, 2'b01, 0, "m1_while_parked");
    step(1, 2'b11, 1, 0, 2'b10, 2'b01, 0, "second_split_ignored");
    step(1, 2'b11, 0, 1, 2'b10, 2'b01, 0, "split_release");
    step(1, 2'b01, 0, 0, 2'b00, 2'b01, 0, "m1_drop_parked");
    step(1, 2'b01, 0, 0, 2'b00, 2'b01, 0, "turn_before_regrant");
    step(1, 2'b01, 0, 0, 2'b01, 2'b00, 0, "split_regrant");

    // tenure guard: grant already visible for 1 cycle, 7 more, then forced revoke
    for (int i = 0; i < HL - 1; i++)
      step(1, 2'b01, 0, 0, 2'b01, 2'b00, 0, "hold_tenure");
    step(1, 2'b01, 0, 0, 2'b00, 2'b00, 1, "hold_revoke");
    step(1, 2'b01, 0, 0, 2'b00, 2'b00, 0, "hold_err_one_cycle");
    step(1, 2'b01, 0, 0, 2'b01, 2'b00, 0, "regrant_after_revoke");
    step(1, 2'b00, 0, 0, 2'b00, 2'b00, 0, "m0_release");
    step(1, 2'b00, 0, 0, 2'b00, 2'b00, 0, "idle_turn");
    step(1, 2'b00, 0, 1, 2'b00, 2'b00, 0, "release_no_split");

    // split accepted together with a release pulse: pulse must not mark it ready
    step(1, 2'b01, 0, 0, 2'b01, 2'b00, 0, "m0_grant_again");
    step(1, 2'b11, 1, 1, 2'b00, 2'b01, 0, "split_with_release");
    step(1, 2'b11, 0, 0, 2'b00, 2'b01, 0, "split2_turn");
    step(1, 2'b11, 0, 0, 2'b10, 2'b01, 0, "m1_not_m0");
    step(1, 2'b10, 0, 0, 2'b10, 2'b00, 0, "abandon_parked");
    step(1, 2'b10, 0, 0, 2'b10, 2'b00, 0, "m1_keeps_bus");
    step(1, 2'b00, 0, 1, 2'b00, 2'b00, 0, "m1_drop_after_abandon");
    step(1, 2'b00, 0, 0, 2'b00, 2'b00, 0, "turn_after_abandon");
    step(1, 2'b00, 0, 0, 2'b00, 2'b00, 0, "m0_not_regranted");

    // arbitration order after m0 was last served
    step(1, 2'b11, 0, 0, 2'b01, 2'b00, 0, "contend_again");
    step(1, 2'b10, 0, 0, 2'b00, 2'b00, 0, "m0_drop_again");
    step(1, 2'b11, 0, 0, 2'b00, 2'b00, 0, "turn_contend");
    step(1, 2'b11, 0, 0, RR_LAST_BG, 2'b00, 0, "priority_scheme");
    step(1, 2'b00, 0, 0, 2'b00, 2'b00, 0, "final_drop");

    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
